// File: rtl/booth_seq_controller_if.sv
// =============================================================================
// booth_seq_controller_if : handshake, Booth-bit and strobe bundle between the
// multiplier top level (master) and the Booth sequencer (slave).  Rev 1.0
// =============================================================================
`default_nettype none

interface booth_seq_controller_if #(
    parameter int CNT_W = 6
);
    logic             start_i;
    logic             ack_i;
    logic [2:0]       booth_bits_i;
    logic             clr_o;
    logic             load_o;
    logic             rwe_A;
    logic             rwe_M;
    logic             rwe_Q;
    logic             rwe_Qlessbit;
    logic             out_res_A_e;
    logic             out_res_Q_e;
    logic             op_en_o;
    logic             op_neg_o;
    logic             op_dbl_o;
    logic             shift2_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] iter_cnt_o;
    logic [2:0]       state_o;

    modport master (
        output start_i, ack_i, booth_bits_i,
        input  clr_o, load_o, rwe_A, rwe_M, rwe_Q, rwe_Qlessbit,
               out_res_A_e, out_res_Q_e, op_en_o, op_neg_o, op_dbl_o,
               shift2_o, busy_o, done_o, iter_cnt_o, state_o
    );

    modport slave (
        input  start_i, ack_i, booth_bits_i,
        output clr_o, load_o, rwe_A, rwe_M, rwe_Q, rwe_Qlessbit,
               out_res_A_e, out_res_Q_e, op_en_o, op_neg_o, op_dbl_o,
               shift2_o, busy_o, done_o, iter_cnt_o, state_o
    );
endinterface

`default_nettype wire

// File: rtl/booth_seq_controller.sv
// =============================================================================
// booth_seq_controller : sequencer for the shift-add Booth mantissa multiplier.
// Define RADIX4_EN for modified-Booth radix-4 (WIDTH/2 iterations).  Rev 1.0
// =============================================================================
`default_nettype none

module booth_seq_controller #(
    parameter int WIDTH = 24
) (
    input  wire logic              clk,
    input  wire logic              reset,
    booth_seq_controller_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef RADIX4_EN
    localparam int N_ITER = WIDTH / 2;
`else
    localparam int N_ITER = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

`ifdef RADIX4_EN
    if (WIDTH % 2 != 0) begin : g_odd_width_check
        $error("booth_seq_controller: WIDTH must be even for radix-4");
    end
`endif

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        ITER = 3'b010,
        DONE = 3'b011
    } state_t;

    typedef struct packed {
        logic clr;
        logic load;
        logic rwe_a;
        logic rwe_m;
        logic rwe_q;
        logic rwe_qless;
        logic res_a;
        logic res_q;
        logic busy;
        logic done;
        logic shift2;
    } strobe_t;

    state_t           state;
    logic [CNT_W-1:0] iter_cnt;
    strobe_t          strobes;
    logic             op_en;
    logic             op_neg;
    logic             op_dbl;

    function automatic state_t next_state(input state_t cur, input logic start,
                                          input logic ack, input logic [CNT_W-1:0] cnt);
        state_t nxt;
        case (cur)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = ITER;
            ITER:    nxt = (cnt == '0) ? DONE : ITER;
            DONE:    nxt = ack ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    // Strobes are registered against the state being entered, so they line up
    // with the state register without a decode stage after the flops.
    function automatic strobe_t strobes_for(input state_t s);
        strobe_t f;
        f = '0;
        case (s)
            IDLE: f.clr = 1'b1;
            LOAD: begin
                f.load  = 1'b1;
                f.rwe_m = 1'b1;
                f.rwe_q = 1'b1;
                f.busy  = 1'b1;
            end
            ITER: begin
                f.rwe_a     = 1'b1;
                f.rwe_q     = 1'b1;
                f.rwe_qless = 1'b1;
                f.busy      = 1'b1;
`ifdef RADIX4_EN
                f.shift2    = 1'b1;
`endif
            end
            DONE: begin
                f.res_a = 1'b1;
                f.res_q = 1'b1;
                f.busy  = 1'b1;
                f.done  = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            iter_cnt <= '0;
            strobes  <= strobes_for(IDLE);
        end else begin
            state   <= next_state(state, bus.start_i, bus.ack_i, iter_cnt);
            strobes <= strobes_for(next_state(state, bus.start_i, bus.ack_i, iter_cnt));
            if (state == LOAD) begin
                iter_cnt <= LAST_CNT;
            end else if ((state == ITER) && (iter_cnt != '0)) begin
                iter_cnt <= iter_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        op_en  = 1'b0;
        op_neg = 1'b0;
        op_dbl = 1'b0;
        if (state == ITER) begin
`ifdef RADIX4_EN
            case (bus.booth_bits_i)
                3'b001, 3'b010: op_en = 1'b1;
                3'b011: begin
                    op_en  = 1'b1;
                    op_dbl = 1'b1;
                end
                3'b100: begin
                    op_en  = 1'b1;
                    op_dbl = 1'b1;
                    op_neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    op_en  = 1'b1;
                    op_neg = 1'b1;
                end
                default: op_en = 1'b0;
            endcase
`else
            case (bus.booth_bits_i[1:0])
                2'b01: op_en = 1'b1;
                2'b10: begin
                    op_en  = 1'b1;
                    op_neg = 1'b1;
                end
                default: op_en = 1'b0;
            endcase
`endif
        end
    end

`ifndef RADIX4_EN
    logic unused_q1;
    assign unused_q1 = bus.booth_bits_i[2];
`endif

    assign bus.clr_o        = strobes.clr;
    assign bus.load_o       = strobes.load;
    assign bus.rwe_A        = strobes.rwe_a;
    assign bus.rwe_M        = strobes.rwe_m;
    assign bus.rwe_Q        = strobes.rwe_q;
    assign bus.rwe_Qlessbit = strobes.rwe_qless;
    assign bus.out_res_A_e  = strobes.res_a;
    assign bus.out_res_Q_e  = strobes.res_q;
    assign bus.busy_o       = strobes.busy;
    assign bus.done_o       = strobes.done;
    assign bus.shift2_o     = strobes.shift2;
    assign bus.op_en_o      = op_en;
    assign bus.op_neg_o     = op_neg;
    assign bus.op_dbl_o     = op_dbl;
    assign bus.iter_cnt_o   = iter_cnt;
    assign bus.state_o      = state;

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_controller.sv
// =============================================================================
// tb_booth_seq_controller : randomized self-checking bench for the Booth
// sequencer against a cycle-schedule reference model.  Rev 1.0
// =============================================================================
`default_nettype none

module tb_booth_seq_controller;

`ifdef RADIX4_EN
    localparam int WIDTH  = 8;
    localparam int N_ITER = WIDTH / 2;
`else
    localparam int WIDTH  = 4;
    localparam int N_ITER = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    // Model: a run is described only by how many edges have passed since its
    // start was accepted; phase and counter follow from that number.
    bit m_active = 1'b0;
    int m_t      = 0;

    booth_seq_controller_if #(.CNT_W(CNT_W)) bus ();

    booth_seq_controller #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // 0 idle, 1 load, 2 iter, 3 done
    function automatic int exp_phase();
        if (!m_active)            return 0;
        if (m_t == 1)             return 1;
        if (m_t <= 1 + N_ITER)    return 2;
        return 3;
    endfunction

    task automatic check_all();
        int          ph;
        int          d;
        logic [10:0] exp_strb;
        logic [10:0] obs_strb;
        logic [2:0]  exp_op;
        logic [2:0]  b;
        int          exp_cnt;
        ph = exp_phase();
        b  = bus.booth_bits_i;
        case (ph)
            0:       exp_strb = 11'b100_0000_0000;
            1:       exp_strb = 11'b010_1100_0100;
`ifdef RADIX4_EN
            2:       exp_strb = 11'b001_0110_0101;
`else
            2:       exp_strb = 11'b001_0110_0100;
`endif
            default: exp_strb = 11'b000_0001_1110;
        endcase
        obs_strb = {bus.clr_o, bus.load_o, bus.rwe_A, bus.rwe_M, bus.rwe_Q, bus.rwe_Qlessbit,
                    bus.out_res_A_e, bus.out_res_Q_e, bus.busy_o, bus.done_o, bus.shift2_o};
`ifdef RADIX4_EN
        d = -2 * int'(b[2]) + int'(b[1]) + int'(b[0]);
`else
        d = int'(b[0]) - int'(b[1]);
`endif
        if (ph == 2) exp_op = {d != 0, d < 0, (d == 2) || (d == -2)};
        else         exp_op = 3'b000;
        exp_cnt = (ph == 2) ? (N_ITER + 1 - m_t) : 0;
        check_eq("state", 32'(bus.state_o), 32'(ph));
        check_eq("strobes", 32'(obs_strb), 32'(exp_strb));
        check_eq("iter_cnt", 32'(bus.iter_cnt_o), 32'(exp_cnt));
        check_eq("op{en,neg,dbl}", 32'({bus.op_en_o, bus.op_neg_o, bus.op_dbl_o}), 32'(exp_op));
    endtask

    task automatic do_cycle(input logic s, input logic a);
        bus.start_i      = s;
        bus.ack_i        = a;
        bus.booth_bits_i = 3'($urandom_range(0, 7));
        @(posedge clk);
        if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_t      = 1;
            end
        end else if (m_t >= 2 + N_ITER) begin
            if (a) m_active = 1'b0;
        end else begin
            m_t++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic run_cycles(input int n, input logic s, input logic a);
        for (int i = 0; i < n; i++) do_cycle(s, a);
    endtask

    // Reset raised between edges; outputs must respond before any clock.
    task automatic async_reset();
        #2 reset = 1'b1;
        m_active = 1'b0;
        m_t      = 0;
        #1 check_all();
        @(negedge clk);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        bus.start_i      = 1'b0;
        bus.ack_i        = 1'b0;
        bus.booth_bits_i = 3'b000;
        #1 reset = 1'b1;
        #1 check_all();
        @(negedge clk);
        check_all();
        reset = 1'b0;

        // Plain run: done held with ack low, then acknowledged.
        run_cycles(2, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b0);
        run_cycles(N_ITER + 1 + 3, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1);
        run_cycles(2, 1'b0, 1'b0);

        // Start held high throughout: one run, one idle cycle, a second run.
        run_cycles(2 + N_ITER + 2, 1'b1, 1'b0);
        do_cycle(1'b1, 1'b1);
        run_cycles(3 + N_ITER, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b1);
        do_cycle(1'b0, 1'b0);

        // Reset during the second ITER cycle, then a complete run.
        do_cycle(1'b1, 1'b0);
        run_cycles(2, 1'b0, 1'b0);
        async_reset();
        run_cycles(N_ITER + 3, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b0);
        run_cycles(N_ITER + 2, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1);

        // Randomized handshake traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) async_reset();
            else do_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
